myproject_mul_share_arb: RTL and testbench

MYPROJECT_MUL_SHARE_ARB -- requirements
Module: myproject_mul_share_arb

---
 rtl/myproject_mul_share_arb.sv | 115 +++++++++++
 tb/tb_myproject_mul_share_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter feeding one shared unsigned x signed multiplier with a NUM_STAGE result pipeline.
// Build option: MYPROJECT_MUL_ARB_SAT_EN clamps the product to DOUT_WIDTH; otherwise it wraps.
module myproject_mul_share_arb #(
  parameter int N_REQ      = 4,
  parameter int DIN0_WIDTH = 3,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 9,
  parameter int NUM_STAGE  = 1,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0]  req_din0,
  input  logic [N_REQ*DIN1_WIDTH-1:0]  req_din1,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DOUT_WIDTH-1:0]        rsp_dout,
  output logic [IDW-1:0]               rsp_id
);

  localparam int FW = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int WW = (FW > DOUT_WIDTH) ? FW : DOUT_WIDTH;

  logic [IDW-1:0]                        r_rr_ptr;
  logic [NUM_STAGE-1:0]                  r_vld_pipe;
  logic [NUM_STAGE-1:0][DOUT_WIDTH-1:0]  r_dout_pipe;
  logic [NUM_STAGE-1:0][IDW-1:0]         r_id_pipe;

  logic                   w_adv;
  logic                   w_found;
  logic                   w_fire;
  logic [IDW-1:0]         w_gnt_idx;
  logic [IDW-1:0]         w_ptr_nxt;
  logic [N_REQ-1:0]       w_gnt_oh;
  logic [DIN0_WIDTH-1:0]  w_din0;
  logic [DIN1_WIDTH-1:0]  w_din1;
  logic signed [FW-1:0]   w_prod;
  logic signed [WW-1:0]   w_prod_ext;
  logic [DOUT_WIDTH-1:0]  w_res;

  // One global stall: the whole pipe moves only when the output slot frees up.
  assign w_adv = !r_vld_pipe[NUM_STAGE-1] || rsp_ready;

  always_comb begin
    int v_sum;
    logic [IDW-1:0] v_idx;
    v_sum     = 0;
    v_idx     = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      v_sum = int'(r_rr_ptr) + off;
      if (v_sum >= N_REQ) v_sum = v_sum - N_REQ;
      v_idx = IDW'(v_sum);
      if (!w_found && req_valid[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
    if (w_found && w_adv && ap_rst_n) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  assign req_ready = w_gnt_oh;
  assign w_fire    = w_found && w_adv && ap_rst_n;
  assign w_ptr_nxt = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

  assign w_din0 = req_din0[w_gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
  assign w_din1 = req_din1[w_gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];

  // Zero-extending din0 by one bit keeps it positive inside the signed multiply.
  assign w_prod     = FW'($signed({1'b0, w_din0})) * FW'($signed(w_din1));
  assign w_prod_ext = WW'(w_prod);

`ifdef MYPROJECT_MUL_ARB_SAT_EN
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  always_comb begin
    w_res = w_prod_ext[DOUT_WIDTH-1:0];
    if (w_prod_ext > SAT_MAX)      w_res = SAT_MAX[DOUT_WIDTH-1:0];
    else if (w_prod_ext < SAT_MIN) w_res = SAT_MIN[DOUT_WIDTH-1:0];
  end
`else
  assign w_res = w_prod_ext[DOUT_WIDTH-1:0];
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr    <= '0;
      r_vld_pipe  <= '0;
      r_dout_pipe <= '0;
      r_id_pipe   <= '0;
    end else begin
      if (w_fire) r_rr_ptr <= w_ptr_nxt;
      if (w_adv) begin
        r_vld_pipe[0]  <= w_fire;
        r_dout_pipe[0] <= w_res;
        r_id_pipe[0]   <= w_gnt_idx;
        for (int s = 1; s < NUM_STAGE; s++) begin
          r_vld_pipe[s]  <= r_vld_pipe[s-1];
          r_dout_pipe[s] <= r_dout_pipe[s-1];
          r_id_pipe[s]   <= r_id_pipe[s-1];
        end
      end
    end
  end

  assign rsp_valid = r_vld_pipe[NUM_STAGE-1];
  assign rsp_dout  = r_dout_pipe[NUM_STAGE-1];
  assign rsp_id    = r_id_pipe[NUM_STAGE-1];

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Bench for myproject_mul_share_arb: 4 requesters, 8-bit result, 2-stage pipe.
module tb_myproject_mul_share_arb;

  localparam int NROW = 29;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_din0;
  logic [23:0] req_din1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_dout;
  logic [1:0]  rsp_id;

  myproject_mul_share_arb #(
    .N_REQ(4), .DIN0_WIDTH(3), .DIN1_WIDTH(6), .DOUT_WIDTH(8), .NUM_STAGE(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_id(rsp_id)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [11:0] d0;
    logic [23:0] d1;
    logic        rdy;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] dout;
  } rsp_t;

  localparam logic [3:0] TV [NROW] = '{4'hF,4'hF,4'hF,4'hF,4'hF,4'hF, 4'h0,4'h0, 4'h1,4'h0,4'h0,
                                       4'h4,4'h1,4'h0,4'h0, 4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,
                                       4'h0,4'h0, 4'h2,4'h0,4'h1,4'h0,4'h0};
  localparam logic       TR [NROW] = '{1,1,1,1,1,1, 1,1, 1,1,1, 1,1,1,1, 1,1,0,0,0,1,1,
                                       1,1, 0,0,0,1,1};
  localparam logic [3:0] TG [NROW] = '{4'h1,4'h2,4'h4,4'h8,4'h1,4'h2, 4'h0,4'h0, 4'h1,4'h0,4'h0,
                                       4'h4,4'h1,4'h0,4'h0, 4'h2,4'h4,4'h0,4'h0,4'h0,4'h8,4'h1,
                                       4'h0,4'h0, 4'h2,4'h0,4'h0,4'h0,4'h0};

  vec_t tbl [NROW];
  rsp_t q_exp [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  function automatic logic [7:0] model(input logic [2:0] a, input logic [5:0] b);
    int p;
    logic signed [5:0] sb;
    sb = b;
    p  = int'(a) * int'(sb);
`ifdef MYPROJECT_MUL_ARB_SAT_EN
    if (p > 127)       p = 127;
    else if (p < -128) p = -128;
`endif
    return p[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle, starting just after a rising edge: drive, check grant, queue expected result.
  task automatic cyc(input logic [3:0] v, input logic [11:0] d0, input logic [23:0] d1,
                     input logic rdy, input logic [3:0] eg, input bit push);
    rsp_t e;
    req_valid = v;
    req_din0  = d0;
    req_din1  = d1;
    rsp_ready = rdy;
    @(negedge ap_clk);
    chk("grant", 32'(req_ready), 32'(eg));
    if (push && eg != 4'h0) begin
      for (int g = 0; g < 4; g++) begin
        if (eg[g]) begin
          e.id   = 2'(g);
          e.dout = model(d0[g*3 +: 3], d1[g*6 +: 6]);
          q_exp.push_back(e);
        end
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every accepted result, checks hold during stalls.
  initial begin
    logic       stall_q;
    logic [7:0] held_dout;
    logic [1:0] held_id;
    rsp_t       e;
    stall_q   = 1'b0;
    held_dout = '0;
    held_id   = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("hold_dout", 32'(rsp_dout), 32'(held_dout));
          chk("hold_id", 32'(rsp_id), 32'(held_id));
        end
        if (rsp_valid && rsp_ready) begin
          if (q_exp.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d dout 0x%0h, expected no result", rsp_id, rsp_dout);
          end else begin
            e = q_exp.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_dout", 32'(rsp_dout), 32'(e.dout));
          end
        end
        stall_q   = rsp_valid && !rsp_ready;
        held_dout = rsp_dout;
        held_id   = rsp_id;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NROW; r++) begin
      tbl[r].vld     = TV[r];
      tbl[r].rdy     = TR[r];
      tbl[r].exp_gnt = TG[r];
      for (int i = 0; i < 4; i++) begin
        tbl[r].d0[i*3 +: 3] = 3'(r*3 + i);
        tbl[r].d1[i*6 +: 6] = 6'(r*11 + i*7 + 5);
      end
    end
    // 7 * -32 = -224 overflows 8 bits: clamps to 0x80 or wraps to 0x20.
    tbl[8].d0[2:0] = 3'd7;
    tbl[8].d1[5:0] = 6'h20;

    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_dout", 32'(rsp_dout), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    req_valid = 4'h0;
    #9 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    for (int r = 0; r < NROW; r++)
      cyc(tbl[r].vld, tbl[r].d0, tbl[r].d1, tbl[r].rdy, tbl[r].exp_gnt, 1'b1);

    // Two grants in flight, then an asynchronous reset between edges.
    cyc(4'hF, 12'o1234, 24'h123456, 1'b1, 4'h4, 1'b0);
    cyc(4'hF, 12'o1234, 24'h123456, 1'b1, 4'h8, 1'b0);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_dout", 32'(rsp_dout), 32'h0);
    chk("midrst_id", 32'(rsp_id), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'h0;
    #4 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc(4'h0, '0, '0, 1'b1, 4'h0, 1'b0);
      chk("no_stale", 32'(rsp_valid), 32'h0);
    end

    // Pointer back at 0 after reset, and two-cycle latency on the first result.
    cyc(4'hF, 12'o5677, 24'hFEDCBA, 1'b1, 4'h1, 1'b1);
    req_valid = 4'h0;
    @(negedge ap_clk);
    chk("lat_stage1", 32'(rsp_valid), 32'h0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("lat_stage2", 32'(rsp_valid), 32'h1);
    @(posedge ap_clk);
    #1;

    for (int k = 0; k < 10 && q_exp.size() != 0; k++)
      cyc(4'h0, '0, '0, 1'b1, 4'h0, 1'b0);
    chk("sb_empty", 32'(q_exp.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
